// File: rtl/core_mem_arbiter_n.sv
// Arbitrates NCH core-side requesters onto one memory port with a single outstanding transaction.
// RR=1 rotates priority after each completion; RR=0 always favours the lowest index.
module core_mem_arbiter_n #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int NCH = 4,
    parameter int RR  = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clk_en,
    input  logic [NCH-1:0]      i_req,
    input  logic [NCH-1:0]      i_we,
    input  logic [NCH*AW-1:0]   i_addr,
    input  logic [NCH*DW-1:0]   i_wdata,
    input  logic [NCH*DW/8-1:0] i_be,
    output logic [NCH-1:0]      o_ack,
    output logic [DW-1:0]       o_rdata,
    output logic [NCH-1:0]      o_stall,
    output logic                o_busy,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [AW-1:0]       o_mem_addr,
    output logic [DW-1:0]       o_mem_wdata,
    output logic [DW/8-1:0]     o_mem_be,
    input  logic                i_mem_ready,
    input  logic                i_mem_ack,
    input  logic [DW-1:0]       i_mem_rdata
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW = DW / 8;

    // IDLE: pick a winner | REQ: request presented to memory | WAIT: accepted, awaiting response
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t         state;
    logic [GW-1:0]  grant, rr_ptr, win_idx, ptr_next;
    logic [NCH-1:0] elig;
    logic           win_found, done;

    logic [AW-1:0]  addr_a  [NCH];
    logic [DW-1:0]  wdata_a [NCH];
    logic [BW-1:0]  be_a    [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign addr_a[g]  = i_addr[g*AW +: AW];
        assign wdata_a[g] = i_wdata[g*DW +: DW];
        assign be_a[g]    = i_be[g*BW +: BW];
        assign o_stall[g] = i_req[g] & ~o_ack[g] & ~(o_busy & (grant == GW'(g)));
    end

    // A channel being acked this cycle already has its result; re-issuing it would duplicate the access.
    assign elig     = i_req & ~o_ack;
    assign o_busy   = (state != IDLE);
    assign done     = ((state == REQ) && i_mem_ready && i_mem_ack) || ((state == WAIT) && i_mem_ack);
    assign ptr_next = (grant == GW'(NCH - 1)) ? '0 : grant + GW'(1);

    always_comb begin
        int k;
        logic [GW-1:0] idx;
        k         = 0;
        idx       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            k   = (RR != 0) ? ((int'(rr_ptr) + i) % NCH) : i;
            idx = GW'(k);
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            o_ack       <= '0;
            o_rdata     <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= '0;
        end else if (i_clk_en) begin
            o_ack <= done ? (NCH'(1) << grant) : '0;
            if (done && !o_mem_we)
                o_rdata <= i_mem_rdata;
            if (done && (RR != 0))
                rr_ptr <= ptr_next;
            case (state)
                IDLE: if (win_found) begin
                    grant       <= win_idx;
                    o_mem_we    <= i_we[win_idx];
                    o_mem_addr  <= addr_a[win_idx];
                    o_mem_wdata <= wdata_a[win_idx];
                    o_mem_be    <= be_a[win_idx];
                    o_mem_req   <= 1'b1;
                    state       <= REQ;
                end
                REQ: if (i_mem_ready) begin
                    o_mem_req <= 1'b0;
                    state     <= i_mem_ack ? IDLE : WAIT;
                end
                WAIT: if (i_mem_ack)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter_n.sv
// Bench for core_mem_arbiter_n: a round-robin and a fixed-priority instance share all stimulus and
// are both compared every cycle against a transaction-level reference model.
module tb_core_mem_arbiter_n;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              rst, clk_en;
    logic [NCH-1:0]    req, we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic [NCH*4-1:0]  be;
    logic              mem_ready, mem_ack;
    logic [DW-1:0]     mem_rdata;

    logic [NCH-1:0] rr_ack, fp_ack, rr_stall, fp_stall;
    logic [DW-1:0]  rr_rdata, fp_rdata, rr_mwdata, fp_mwdata;
    logic [AW-1:0]  rr_maddr, fp_maddr;
    logic [3:0]     rr_mbe, fp_mbe;
    logic           rr_busy, fp_busy, rr_mreq, fp_mreq, rr_mwe, fp_mwe;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    core_mem_arbiter_n #(.AW(AW), .DW(DW), .NCH(NCH), .RR(1)) dut_rr (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_be(be), .o_ack(rr_ack), .o_rdata(rr_rdata), .o_stall(rr_stall),
        .o_busy(rr_busy), .o_mem_req(rr_mreq), .o_mem_we(rr_mwe), .o_mem_addr(rr_maddr),
        .o_mem_wdata(rr_mwdata), .o_mem_be(rr_mbe), .i_mem_ready(mem_ready), .i_mem_ack(mem_ack),
        .i_mem_rdata(mem_rdata));

    core_mem_arbiter_n #(.AW(AW), .DW(DW), .NCH(NCH), .RR(0)) dut_fp (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_be(be), .o_ack(fp_ack), .o_rdata(fp_rdata), .o_stall(fp_stall),
        .o_busy(fp_busy), .o_mem_req(fp_mreq), .o_mem_we(fp_mwe), .o_mem_addr(fp_maddr),
        .o_mem_wdata(fp_mwdata), .o_mem_be(fp_mbe), .i_mem_ready(mem_ready), .i_mem_ack(mem_ack),
        .i_mem_rdata(mem_rdata));

    // Reference: one transaction in flight, owner and latched fields, acked channel, priority pointer.
    typedef struct {
        bit         busy;
        bit         presented;
        int         owner;
        int         ptr;
        logic [3:0] ack;
        logic [31:0] rdata;
        logic       mwe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0] mbe;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.busy = 0; r.presented = 0; r.owner = 0; r.ptr = 0; r.ack = '0; r.rdata = '0;
        r.mwe = 0; r.maddr = '0; r.mwdata = '0; r.mbe = '0;
        return r;
    endfunction

    // Winner = eligible channel at the smallest rotational distance from ptr (or lowest index).
    function automatic int pick(bit rr, logic [3:0] elig, int ptr);
        int best = -1;
        int best_d = NCH;
        for (int k = 0; k < NCH; k++) begin
            int d;
            d = rr ? ((k - ptr + NCH) % NCH) : k;
            if (elig[k] && d < best_d) begin best = k; best_d = d; end
        end
        return best;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, bit rr);
        mdl_t n = s;
        int   w;
        bit   fin = 0;
        n.ack = '0;
        if (!s.busy) begin
            w = pick(rr, req & ~s.ack, s.ptr);
            if (w >= 0) begin
                n.busy = 1; n.presented = 1; n.owner = w;
                n.mwe = we[w]; n.maddr = addr[w*32 +: 32];
                n.mwdata = wdata[w*32 +: 32]; n.mbe = be[w*4 +: 4];
            end
        end else if (s.presented) begin
            if (mem_ready) begin n.presented = 0; fin = mem_ack; end
        end else begin
            fin = mem_ack;
        end
        if (fin) begin
            n.busy = 0;
            n.ack[s.owner] = 1'b1;
            if (!s.mwe) n.rdata = mem_rdata;
            if (rr) n.ptr = (s.owner + 1) % NCH;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m[0] <= mdl_reset();
            m[1] <= mdl_reset();
        end else if (clk_en) begin
            m[0] <= mdl_step(m[0], 1'b1);
            m[1] <= mdl_step(m[1], 1'b0);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_stall(mdl_t s);
        logic [3:0] r;
        for (int k = 0; k < NCH; k++)
            r[k] = req[k] & ~s.ack[k] & ~(s.busy && s.owner == k);
        return r;
    endfunction

    task automatic cmp(input string tag, input logic [3:0] a, input logic [31:0] rd,
                       input logic [3:0] st, input logic bz, input logic mq, input logic mw,
                       input logic [31:0] ma, input logic [31:0] md, input logic [3:0] mb,
                       input mdl_t s);
        check({tag, " ack"},   128'(a),  128'(s.ack));
        check({tag, " rdata"}, 128'(rd), 128'(s.rdata));
        check({tag, " stall"}, 128'(st), 128'(exp_stall(s)));
        check({tag, " busy"},  128'(bz), 128'(s.busy));
        check({tag, " mreq"},  128'(mq), 128'(s.busy && s.presented));
        check({tag, " mfields"}, {59'd0, mw, ma, md, mb}, {59'd0, s.mwe, s.maddr, s.mwdata, s.mbe});
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("rr", rr_ack, rr_rdata, rr_stall, rr_busy, rr_mreq, rr_mwe, rr_maddr, rr_mwdata, rr_mbe, m[0]);
            cmp("fp", fp_ack, fp_rdata, fp_stall, fp_busy, fp_mreq, fp_mwe, fp_maddr, fp_mwdata, fp_mbe, m[1]);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        req[k] = r; we[k] = w;
        addr[k*32 +: 32] = a; wdata[k*32 +: 32] = d; be[k*4 +: 4] = b;
    endtask

    function automatic int oh_idx(logic [3:0] v);
        for (int k = 0; k < NCH; k++) if (v[k]) return k;
        return -1;
    endfunction

    typedef struct {
        int          ch;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        int          rdy_dly;
        int          ack_dly;
        logic [31:0] mrd;
        logic [3:0]  exp_ack;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input vec_t v);
        set_ch(v.ch, 1'b1, v.w, v.a, v.d, v.b);
        mem_ready = 0; mem_ack = 0; mem_rdata = v.mrd;
        step();
        check("vec mreq", 128'(rr_mreq), 128'(1));
        check("vec fields", {59'd0, rr_mwe, rr_maddr, rr_mwdata, rr_mbe}, {59'd0, v.w, v.a, v.d, v.b});
        for (int i = 0; i < v.rdy_dly; i++) begin
            step();
            check("vec hold", {58'd0, rr_mreq, rr_mwe, rr_maddr, rr_mwdata, rr_mbe},
                              {58'd0, 1'b1, v.w, v.a, v.d, v.b});
        end
        mem_ready = 1; mem_ack = (v.ack_dly == 0);
        step();
        if (v.ack_dly != 0) begin
            check("vec mreq drop", 128'({rr_mreq, rr_busy}), 128'(2'b01));
            mem_ready = 0; mem_ack = 0;
            for (int i = 1; i < v.ack_dly; i++) begin
                step();
                check("vec wait", 128'(rr_ack), 128'(0));
            end
            mem_ack = 1;
            step();
        end
        check("vec ack rr", 128'(rr_ack), 128'(v.exp_ack));
        check("vec ack fp", 128'(fp_ack), 128'(v.exp_ack));
        mem_ack = 0; mem_ready = 0; req[v.ch] = 0;
        step();
        check("vec ack pulse", 128'(rr_ack), 128'(0));
        check("vec rdata", 128'(rr_rdata), 128'(v.exp_rdata));
        check("vec idle", 128'(rr_busy), 128'(0));
    endtask

    initial begin
        int rr_g[$];
        int fp_g[$];
        int n_ack, n_req, n_dup, n_high, n_pulse, n_bad, cyc;
        logic [3:0] prev_ack;
        logic [71:0] snap;

        vecs[0] = '{1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 2, 32'hDEAD_BEEF, 4'b0010, 32'hDEAD_BEEF};
        vecs[1] = '{2, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'b0110, 5, 1, 32'hBADB_AD00, 4'b0100, 32'hDEAD_BEEF};
        vecs[2] = '{0, 1'b0, 32'h0000_0008, 32'h0, 4'hF, 0, 0, 32'hCAFE_F00D, 4'b0001, 32'hCAFE_F00D};
        vecs[3] = '{3, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 2, 3, 32'h1234_5678, 4'b1000, 32'h1234_5678};
        vecs[4] = '{3, 1'b1, 32'h0000_0000, 32'hFFFF_0000, 4'hF, 1, 0, 32'h0BAD_0BAD, 4'b1000, 32'h1234_5678};

        rst = 1; clk_en = 1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        mem_ready = 0; mem_ack = 0; mem_rdata = '0;
        repeat (3) step();
        check("reset outputs", {rr_ack, rr_rdata, rr_busy, rr_mreq, rr_mwe, rr_maddr, rr_mbe},
                               128'(0));
        check("reset fp outputs", {fp_ack, fp_rdata, fp_busy, fp_mreq, fp_maddr}, 128'(0));
        rst = 0;
        chk_on = 1;
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // All channels requesting; the ack-cycle exclusion hands the fixed-priority slot to ch1 alternately.
        for (int k = 0; k < NCH; k++) set_ch(k, 1'b1, 1'b0, 32'(k * 16), 32'h0, 4'hF);
        mem_ready = 1; mem_ack = 1; mem_rdata = 32'h5555_AAAA;
        for (int c = 0; c < 16; c++) begin
            step();
            if (rr_ack != 0) rr_g.push_back(oh_idx(rr_ack));
            if (fp_ack != 0) fp_g.push_back(oh_idx(fp_ack));
        end
        check("rr grant count", 128'(rr_g.size()), 128'(8));
        check("fp grant count", 128'(fp_g.size()), 128'(8));
        for (int i = 0; i < rr_g.size() && i < 8; i++) begin
            check("rr grant order", 128'(rr_g[i]), 128'(i % 4));
            check("fp grant order", 128'(fp_g[i]), 128'(i % 2));
        end
        req = '0; mem_ready = 0; mem_ack = 0;
        repeat (2) step();

        // Back-to-back on ch0 with same-cycle ready+ack.
        set_ch(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        mem_ready = 1; mem_ack = 1; mem_rdata = 32'h0F0F_0F0F;
        n_ack = 0; n_req = 0; n_dup = 0; prev_ack = '0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (rr_ack[0]) n_ack++;
            if (rr_mreq) n_req++;
            if (prev_ack[0] && rr_mreq) n_dup++;
            prev_ack = rr_ack;
        end
        check("b2b acks", 128'(n_ack), 128'(10));
        check("b2b mem reqs", 128'(n_req), 128'(10));
        check("b2b duplicate issue", 128'(n_dup), 128'(0));
        req = '0; mem_ready = 0; mem_ack = 0;
        repeat (2) step();

        // Clock enable alternating: every ack pulse must span the following disabled edge.
        set_ch(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        mem_ready = 1; mem_ack = 1; mem_rdata = 32'h7777_1111;
        n_high = 0; n_pulse = 0; n_bad = 0; prev_ack = '0; cyc = 0;
        while (cyc < 200 && !(n_pulse == 10 && rr_ack == 0)) begin
            clk_en = (cyc % 2 == 0);
            snap = {rr_ack, rr_busy, rr_mreq, rr_rdata, rr_maddr, 2'b00};
            step();
            if (!clk_en && snap != {rr_ack, rr_busy, rr_mreq, rr_rdata, rr_maddr, 2'b00}) n_bad++;
            if (rr_ack[1]) n_high++;
            if (rr_ack[1] && !prev_ack[1]) n_pulse++;
            prev_ack = rr_ack;
            cyc++;
        end
        check("clken bounded", 128'(cyc < 200), 128'(1));
        check("clken ack pulses", 128'(n_pulse), 128'(10));
        check("clken ack high cycles", 128'(n_high), 128'(20));
        check("clken disabled-edge changes", 128'(n_bad), 128'(0));
        clk_en = 1; req = '0; mem_ready = 0; mem_ack = 0;
        repeat (2) step();

        // Reset while waiting for the response.
        set_ch(2, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
        step();
        mem_ready = 1;
        step();
        check("pre-reset wait", 128'({rr_busy, rr_mreq}), 128'(2'b10));
        mem_ready = 0;
        rst = 1;
        #1;
        check("reset immediate", 128'({rr_mreq, rr_busy, rr_ack, fp_mreq, fp_busy, fp_ack}), 128'(0));
        check("reset rdata", 128'(rr_rdata), 128'(0));
        step();
        rst = 0; req[2] = 0; mem_ack = 1; mem_rdata = 32'hEEEE_EEEE;
        step();
        check("late ack ignored", 128'({rr_ack, rr_busy, rr_rdata}), 128'(0));
        set_ch(3, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        mem_ready = 1; mem_ack = 1; mem_rdata = 32'hA5A5_A5A5;
        step();
        check("post-reset issue", 128'({rr_mreq, rr_maddr}), {95'd0, 1'b1, 32'h0000_0300});
        step();
        check("post-reset ack", 128'(rr_ack), 128'(4'b1000));
        check("post-reset rdata", 128'(rr_rdata), 128'(32'hA5A5_A5A5));
        req = '0; mem_ready = 0; mem_ack = 0;
        repeat (2) step();

        // Randomised traffic: stale acks, dropped requests, gated clock, variable latency.
        for (int c = 0; c < 1500; c++) begin
            clk_en    = ($urandom_range(0, 9) != 0);
            mem_ready = 1'($urandom_range(0, 1));
            mem_ack   = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            for (int k = 0; k < NCH; k++) begin
                if (!req[k]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_ch(k, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
                end else if ((m[0].ack[k] && $urandom_range(0, 1) == 0) || $urandom_range(0, 49) == 0) begin
                    req[k] = 0;
                end
            end
            step();
        end

        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
